tp_snd_cmd_if: RTL and testbench

- CPU-board half of the main-CPU ↔ sound-board link: the transmitter side of the sound-command latch / IRQ trigger / controls-read interface.
- Decodes main Z80 bus cycles in the C000–C3FF window.
- Drives sound command data, cs_sounddata and irq_trigger toward the sound PCB model.
- Implements the 74LS259 main-board addressable latch and generates the controls/DIP read selects.

---
 rtl/tp_snd_cmd_if_if.sv | 19 +
 rtl/tp_snd_cmd_if.sv | 166 ++++++++++++++++
 tb/tb_tp_snd_cmd_if.sv | 347 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tp_snd_cmd_if_if.sv
// Main Z80 bus bundle as seen by the CPU-board sound-command interface.
// The master modport is the CPU side (or a bench), the slave modport is
// the decoder that watches the bus.
interface tp_snd_cmd_if_if;
    logic [15:0] cpu_A;
    logic [7:0]  cpu_Dout;
    logic        n_mreq;
    logic        n_rd;
    logic        n_wr;
    logic        n_rfsh;

    modport master (
        output cpu_A, cpu_Dout, n_mreq, n_rd, n_wr, n_rfsh
    );

    modport slave (
        input cpu_A, cpu_Dout, n_mreq, n_rd, n_wr, n_rfsh
    );
endinterface

// File: rtl/tp_snd_cmd_if.sv
// CPU-board half of the main-CPU <-> sound-board link.
// Decodes main Z80 cycles in C000-C3FF: sound command latch (C000), watchdog
// kick (C200), 74LS259 addressable latch (C300-C3FF) and controls/DIP reads.
// Optional watchdog is compiled in with the TP_WATCHDOG_EN macro; without it
// wdog_rst_n is tied high and C200 writes have no effect.
module tp_snd_cmd_if #(
    parameter int WDOG_FRAMES = 16,
    parameter int WDOG_PULSE  = 64
) (
    input  logic                 clk_49m,
    input  logic                 reset,
    input  logic                 cen_3m,
    tp_snd_cmd_if_if.slave       bus,
    input  logic                 vblank,
    output logic [7:0]           cpubrd_Dout,
    output logic                 cs_sounddata,
    output logic                 irq_trigger,
    output logic                 cs_controls_dip1,
    output logic                 cs_dip2,
    output logic                 cpubrd_A5,
    output logic                 cpubrd_A6,
    output logic                 nmi_en,
    output logic                 flip,
    output logic                 coin_cnt1,
    output logic                 coin_cnt2,
    output logic                 wdog_rst_n
);

    logic       mem, wr_win, rd_cyc;
    logic       sel_snd, sel_wdog, sel_latch;
    logic       sel_snd_q, sel_snd_d;
    logic       sel_latch_q, sel_latch_d;
    logic [7:0] dout_q, dout_d;
    logic       cs_q, cs_d;
    logic       irq_q, irq_d;
    logic [7:0] latch_q, latch_d;
    logic       snd_edge, latch_edge;

    // Refresh cycles also pull MREQ low, so they are excluded from decode.
    assign mem    = ~bus.n_mreq & bus.n_rfsh;
    assign wr_win = mem & ~bus.n_wr & (bus.cpu_A[15:10] == 6'b110000);
    assign rd_cyc = mem & ~bus.n_rd;

    assign sel_snd   = wr_win & (bus.cpu_A[9:8] == 2'b00);
    assign sel_wdog  = wr_win & (bus.cpu_A[9:8] == 2'b10);
    assign sel_latch = wr_win & (bus.cpu_A[9:8] == 2'b11);

    assign cs_dip2          = rd_cyc & (bus.cpu_A[15:8] == 8'hC2);
    assign cs_controls_dip1 = rd_cyc & (bus.cpu_A[15:8] == 8'hC3) & ~bus.cpu_A[7];
    assign cpubrd_A5        = bus.cpu_A[5];
    assign cpubrd_A6        = bus.cpu_A[6];

    assign cpubrd_Dout  = dout_q;
    assign cs_sounddata = cs_q;
    assign irq_trigger  = irq_q;
    assign nmi_en       = latch_q[0];
    assign flip         = latch_q[1];
    assign coin_cnt1    = latch_q[5];
    assign coin_cnt2    = latch_q[6];

    // Edge-detect the write selects, update the command byte and the latch,
    // and hold each strobe until the sound board's cen_3m has sampled it.
    always_comb begin
        sel_snd_d   = sel_snd;
        sel_latch_d = sel_latch;
        dout_d      = dout_q;
        latch_d     = latch_q;
        snd_edge    = sel_snd & ~sel_snd_q;
        latch_edge  = sel_latch & ~sel_latch_q;
        if (snd_edge) begin
            dout_d = bus.cpu_Dout;
        end
        if (latch_edge) begin
            latch_d[bus.cpu_A[3:1]] = bus.cpu_Dout[0];
        end
        // A fresh set beats a coincident cen_3m clear.
        cs_d  = snd_edge ? 1'b1 : (cs_q & ~cen_3m);
        irq_d = (latch_d[2] & ~latch_q[2]) ? 1'b1 : (irq_q & ~cen_3m);
    end

    // Command, strobe and latch registers.
    always_ff @(posedge clk_49m or negedge reset) begin
        if (!reset) begin
            sel_snd_q   <= 1'b0;
            sel_latch_q <= 1'b0;
            dout_q      <= 8'h00;
            cs_q        <= 1'b0;
            irq_q       <= 1'b0;
            latch_q     <= 8'h00;
        end else begin
            sel_snd_q   <= sel_snd_d;
            sel_latch_q <= sel_latch_d;
            dout_q      <= dout_d;
            cs_q        <= cs_d;
            irq_q       <= irq_d;
            latch_q     <= latch_d;
        end
    end

`ifdef TP_WATCHDOG_EN
    localparam int FW = $clog2(WDOG_FRAMES + 1);
    localparam int PW = $clog2(WDOG_PULSE + 1);

    logic          sel_wdog_q, sel_wdog_d;
    logic          vblank_q, vblank_d;
    logic [FW-1:0] frame_q, frame_d;
    logic [PW-1:0] pulse_q, pulse_d;
    logic          wdog_n_q, wdog_n_d;

    assign wdog_rst_n = wdog_n_q;

    // Count frames since the last kick; once the limit is reached emit a
    // fixed-length reset pulse that kicks cannot cut short.
    always_comb begin
        sel_wdog_d = sel_wdog;
        vblank_d   = vblank;
        frame_d    = frame_q;
        pulse_d    = pulse_q;
        wdog_n_d   = wdog_n_q;
        if (!wdog_n_q) begin
            if (pulse_q == PW'(WDOG_PULSE - 1)) begin
                wdog_n_d = 1'b1;
                pulse_d  = '0;
                frame_d  = '0;
            end else begin
                pulse_d = pulse_q + 1'b1;
            end
        end else begin
            if (sel_wdog & ~sel_wdog_q) begin
                frame_d = '0;
            end else if (vblank & ~vblank_q) begin
                frame_d = frame_q + 1'b1;
            end
            if (frame_d == FW'(WDOG_FRAMES)) begin
                wdog_n_d = 1'b0;
            end
        end
    end

    // Watchdog registers.
    always_ff @(posedge clk_49m or negedge reset) begin
        if (!reset) begin
            sel_wdog_q <= 1'b0;
            vblank_q   <= 1'b0;
            frame_q    <= '0;
            pulse_q    <= '0;
            wdog_n_q   <= 1'b1;
        end else begin
            sel_wdog_q <= sel_wdog_d;
            vblank_q   <= vblank_d;
            frame_q    <= frame_d;
            pulse_q    <= pulse_d;
            wdog_n_q   <= wdog_n_d;
        end
    end
`else
    logic unused_wdog;
    assign wdog_rst_n  = 1'b1;
    assign unused_wdog = &{1'b0, vblank, sel_wdog, (WDOG_FRAMES > 0), (WDOG_PULSE > 0)};
`endif

    // Address lines the decode does not look at.
    logic unused_addr;
    assign unused_addr = &{1'b0, bus.cpu_A[4], bus.cpu_A[0]};

endmodule

// File: tb/tb_tp_snd_cmd_if.sv
module tb_tp_snd_cmd_if;

    logic       clk_49m = 1'b0;
    logic       reset;
    logic       cen_3m;
    logic       vblank;
    logic [7:0] cpubrd_Dout;
    logic       cs_sounddata, irq_trigger, cs_controls_dip1, cs_dip2;
    logic       cpubrd_A5, cpubrd_A6, nmi_en, flip, coin_cnt1, coin_cnt2, wdog_rst_n;

    always #5 clk_49m = ~clk_49m;

    tp_snd_cmd_if_if bus ();

    tp_snd_cmd_if #(.WDOG_FRAMES(4), .WDOG_PULSE(64)) dut (
        .clk_49m          (clk_49m),
        .reset            (reset),
        .cen_3m           (cen_3m),
        .bus              (bus.slave),
        .vblank           (vblank),
        .cpubrd_Dout      (cpubrd_Dout),
        .cs_sounddata     (cs_sounddata),
        .irq_trigger      (irq_trigger),
        .cs_controls_dip1 (cs_controls_dip1),
        .cs_dip2          (cs_dip2),
        .cpubrd_A5        (cpubrd_A5),
        .cpubrd_A6        (cpubrd_A6),
        .nmi_en           (nmi_en),
        .flip             (flip),
        .coin_cnt1        (coin_cnt1),
        .coin_cnt2        (coin_cnt2),
        .wdog_rst_n       (wdog_rst_n)
    );

    int total = 0;
    int bad   = 0;

    // Reference model state: what the sound board should currently see.
    logic [7:0] exp_dout;
    logic [7:0] exp_latch;
    logic       exp_cs, exp_irq;
    logic       pend_snd, pend_latch, pend_bit;
    logic [7:0] pend_data;
    logic [2:0] pend_idx;
    int         cen_cnt;
    int         cs_rises, irq_rises, cs_high, wdog_low;
    logic       prev_cs, prev_irq;

    function automatic logic in_rng(input logic [15:0] a, input logic [15:0] lo, input logic [15:0] hi);
        return (a >= lo) && (a <= hi);
    endfunction

    function automatic logic exp_dip2_f();
        return !bus.n_mreq && bus.n_rfsh && !bus.n_rd && in_rng(bus.cpu_A, 16'hC200, 16'hC2FF);
    endfunction

    function automatic logic exp_dip1_f();
        return !bus.n_mreq && bus.n_rfsh && !bus.n_rd && in_rng(bus.cpu_A, 16'hC300, 16'hC37F);
    endfunction

    task automatic model_clear();
        exp_dout = 8'h00; exp_latch = 8'h00; exp_cs = 1'b0; exp_irq = 1'b0;
        pend_snd = 1'b0; pend_latch = 1'b0; pend_bit = 1'b0; pend_data = 8'h00; pend_idx = 3'd0;
        prev_cs = 1'b0; prev_irq = 1'b0;
    endtask

    task automatic bus_idle();
        bus.n_mreq = 1'b1; bus.n_rd = 1'b1; bus.n_wr = 1'b1; bus.n_rfsh = 1'b1;
        bus.cpu_A = 16'($urandom); bus.cpu_Dout = 8'($urandom);
    endtask

    // One clock: advance the model across the coming edge, then compare.
    task automatic tick();
        logic set_snd, set_irq;
        set_snd = 1'b0; set_irq = 1'b0;
        if (pend_snd) begin
            exp_dout = pend_data; set_snd = 1'b1; pend_snd = 1'b0;
        end
        if (pend_latch) begin
            if (pend_idx == 3'd2 && pend_bit && !exp_latch[2]) set_irq = 1'b1;
            exp_latch[pend_idx] = pend_bit;
            pend_latch = 1'b0;
        end
        if (set_snd) exp_cs = 1'b1; else if (exp_cs && cen_3m) exp_cs = 1'b0;
        if (set_irq) exp_irq = 1'b1; else if (exp_irq && cen_3m) exp_irq = 1'b0;
        @(posedge clk_49m); #1;
        cen_cnt = (cen_cnt + 1) % 16;
        cen_3m = (cen_cnt == 0);
        if (cs_sounddata === 1'b1 && prev_cs !== 1'b1) cs_rises++;
        if (irq_trigger === 1'b1 && prev_irq !== 1'b1) irq_rises++;
        if (cs_sounddata === 1'b1) cs_high++;
        if (wdog_rst_n === 1'b0) wdog_low++;
        prev_cs = cs_sounddata; prev_irq = irq_trigger;
        total++;
        if (cpubrd_Dout !== exp_dout) begin
            bad++; $display("FAIL dout: got %h want %h at %0t", cpubrd_Dout, exp_dout, $time);
        end
        total++;
        if (cs_sounddata !== exp_cs) begin
            bad++; $display("FAIL cs_sounddata: got %b want %b at %0t", cs_sounddata, exp_cs, $time);
        end
        total++;
        if (irq_trigger !== exp_irq) begin
            bad++; $display("FAIL irq_trigger: got %b want %b at %0t", irq_trigger, exp_irq, $time);
        end
        total++;
        if ({coin_cnt2, coin_cnt1, flip, nmi_en} !== {exp_latch[6], exp_latch[5], exp_latch[1], exp_latch[0]}) begin
            bad++; $display("FAIL latch_out: got %b want %b at %0t", {coin_cnt2, coin_cnt1, flip, nmi_en},
                            {exp_latch[6], exp_latch[5], exp_latch[1], exp_latch[0]}, $time);
        end
        total++;
        if ({cs_dip2, cs_controls_dip1, cpubrd_A6, cpubrd_A5} !==
            {exp_dip2_f(), exp_dip1_f(), bus.cpu_A[6], bus.cpu_A[5]}) begin
            bad++; $display("FAIL read_dec: got %b want %b addr %h", {cs_dip2, cs_controls_dip1, cpubrd_A6, cpubrd_A5},
                            {exp_dip2_f(), exp_dip1_f(), bus.cpu_A[6], bus.cpu_A[5]}, bus.cpu_A);
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Write cycle: select held `hold` clocks, then one idle clock.
    task automatic bus_write(input logic [15:0] a, input logic [7:0] d, input int hold, input logic rfsh);
        bus.cpu_A = a; bus.cpu_Dout = d; bus.n_mreq = 1'b0; bus.n_wr = 1'b0; bus.n_rd = 1'b1;
        bus.n_rfsh = ~rfsh;
        if (!rfsh) begin
            if (in_rng(a, 16'hC000, 16'hC0FF)) begin
                pend_snd = 1'b1; pend_data = d;
            end else if (in_rng(a, 16'hC300, 16'hC3FF)) begin
                pend_latch = 1'b1; pend_idx = a[3:1]; pend_bit = d[0];
            end
        end
        ticks(hold);
        bus_idle();
        tick();
    endtask

    task automatic apply_reset();
        bus_idle();
        vblank = 1'b0;
        #2 reset = 1'b0;
        model_clear();
        @(posedge clk_49m); @(posedge clk_49m);
        @(negedge clk_49m);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        bus_idle();
        vblank = 1'b0;
        reset = 1'b0;
        model_clear();
        @(posedge clk_49m); #1;
        total++;
        if ({cpubrd_Dout, cs_sounddata, irq_trigger, nmi_en, flip, coin_cnt1, coin_cnt2, wdog_rst_n} !== 15'h0001) begin
            bad++; $display("FAIL reset_state: got %h want %h",
                {cpubrd_Dout, cs_sounddata, irq_trigger, nmi_en, flip, coin_cnt1, coin_cnt2, wdog_rst_n}, 15'h0001);
        end
        @(negedge clk_49m);
        reset = 1'b1;
        ticks(3);
    endtask

    task automatic test_sound_write();
        int r0, h0;
        r0 = cs_rises; h0 = cs_high;
        bus_write(16'hC000, 8'h5A, 40, 1'b0);
        ticks(20);
        total++;
        if (cs_rises - r0 != 1) begin
            bad++; $display("FAIL snd_pulse_count: got %0d want 1", cs_rises - r0);
        end
        total++;
        if (cs_high - h0 < 1 || cs_high - h0 > 16) begin
            bad++; $display("FAIL snd_pulse_width: got %0d want 1..16", cs_high - h0);
        end
        total++;
        if (cpubrd_Dout !== 8'h5A) begin
            bad++; $display("FAIL snd_data_hold: got %h want 5a", cpubrd_Dout);
        end
    endtask

    task automatic test_irq();
        int r0;
        r0 = irq_rises;
        bus_write(16'hC304, 8'h01, 3, 1'b0); ticks(20);
        total++;
        if (irq_rises - r0 != 1) begin
            bad++; $display("FAIL irq_first: got %0d want 1", irq_rises - r0);
        end
        r0 = irq_rises;
        bus_write(16'hC304, 8'h01, 3, 1'b0); ticks(20);
        total++;
        if (irq_rises - r0 != 0) begin
            bad++; $display("FAIL irq_rewrite: got %0d want 0", irq_rises - r0);
        end
        r0 = irq_rises;
        bus_write(16'hC304, 8'h00, 2, 1'b0); ticks(20);
        bus_write(16'hC304, 8'hFF, 2, 1'b0); ticks(20);
        total++;
        if (irq_rises - r0 != 1) begin
            bad++; $display("FAIL irq_0_then_1: got %0d want 1", irq_rises - r0);
        end
    endtask

    task automatic test_latch();
        bus_write(16'hC302, 8'h01, 2, 1'b0);
        bus_write(16'hC30A, 8'h01, 2, 1'b0);
        bus_write(16'hC30C, 8'h01, 2, 1'b0);
        bus_write(16'hC300, 8'h01, 2, 1'b0);
        total++;
        if ({nmi_en, flip, coin_cnt1, coin_cnt2} !== 4'b1111) begin
            bad++; $display("FAIL latch_set: got %b want 1111", {nmi_en, flip, coin_cnt1, coin_cnt2});
        end
        bus_write(16'hC382, 8'h00, 2, 1'b0);
        total++;
        if ({nmi_en, flip, coin_cnt1, coin_cnt2} !== 4'b1011) begin
            bad++; $display("FAIL latch_mirror: got %b want 1011", {nmi_en, flip, coin_cnt1, coin_cnt2});
        end
    endtask

    task automatic test_reads();
        bus.cpu_A = 16'hC340; bus.n_mreq = 1'b0; bus.n_rd = 1'b0; bus.n_rfsh = 1'b1;
        #1;
        total++;
        if ({cs_controls_dip1, cs_dip2, cpubrd_A6, cpubrd_A5} !== 4'b1010) begin
            bad++; $display("FAIL read_c340: got %b want 1010", {cs_controls_dip1, cs_dip2, cpubrd_A6, cpubrd_A5});
        end
        tick();
        bus.cpu_A = 16'hC200;
        #1;
        total++;
        if ({cs_controls_dip1, cs_dip2} !== 2'b01) begin
            bad++; $display("FAIL read_c200: got %b want 01", {cs_controls_dip1, cs_dip2});
        end
        tick();
        bus.cpu_A = 16'hC300; bus.n_rfsh = 1'b0;
        #1;
        total++;
        if ({cs_controls_dip1, cs_dip2} !== 2'b00) begin
            bad++; $display("FAIL read_refresh: got %b want 00", {cs_controls_dip1, cs_dip2});
        end
        tick();
        bus_idle();
        tick();
    endtask

    task automatic test_reset_mid_pulse();
        bus.cpu_A = 16'hC000; bus.cpu_Dout = 8'hA7; bus.n_mreq = 1'b0; bus.n_wr = 1'b0;
        pend_snd = 1'b1; pend_data = 8'hA7;
        tick();
        total++;
        if (cs_sounddata !== 1'b1) begin
            bad++; $display("FAIL mid_pulse_setup: got %b want 1", cs_sounddata);
        end
        #2 reset = 1'b0;
        #1;
        total++;
        if ({cs_sounddata, irq_trigger, cpubrd_Dout} !== 10'h000) begin
            bad++; $display("FAIL async_reset: got %h want 000", {cs_sounddata, irq_trigger, cpubrd_Dout});
        end
        bus_idle();
        model_clear();
        @(negedge clk_49m);
        reset = 1'b1;
        ticks(2);
    endtask

    task automatic test_random();
        for (int n = 0; n < 150; n++) begin
            int kind;
            logic [15:0] a;
            logic [7:0] d;
            kind = $urandom_range(0, 5);
            d = 8'($urandom);
            case (kind)
                0: a = 16'hC000 | 16'($urandom_range(0, 255));
                1: a = 16'hC300 | 16'($urandom_range(0, 255));
                2: a = 16'hC200 | 16'($urandom_range(0, 255));
                3: a = 16'($urandom);
                default: a = 16'hC000 | 16'($urandom_range(0, 1023));
            endcase
            if (kind == 5) begin
                bus.cpu_A = a; bus.n_mreq = 1'b0; bus.n_rd = 1'b0; bus.n_rfsh = 1'($urandom_range(0, 1));
                ticks($urandom_range(1, 3));
                bus_idle();
                tick();
            end else begin
                bus_write(a, d, $urandom_range(1, 6), (kind == 4));
            end
            ticks($urandom_range(0, 3));
        end
    endtask

    task automatic vb_pulses(input int n);
        for (int i = 0; i < n; i++) begin
            vblank = 1'b1; ticks(3);
            vblank = 1'b0; ticks(3);
        end
    endtask

    task automatic test_watchdog();
        apply_reset();
        wdog_low = 0;
        vb_pulses(4);
        ticks(150);
`ifdef TP_WATCHDOG_EN
        total++;
        if (wdog_low != 64) begin
            bad++; $display("FAIL wdog_pulse_len: got %0d want 64", wdog_low);
        end
`else
        total++;
        if (wdog_low != 0) begin
            bad++; $display("FAIL wdog_disabled: got %0d low clocks want 0", wdog_low);
        end
`endif
        apply_reset();
        wdog_low = 0;
        vb_pulses(3);
        bus_write(16'hC200, 8'h00, 2, 1'b0);
        vb_pulses(3);
        ticks(20);
        total++;
        if (wdog_low != 0 || wdog_rst_n !== 1'b1) begin
            bad++; $display("FAIL wdog_kicked: got %0d low clocks, now %b want 0 and 1", wdog_low, wdog_rst_n);
        end
    endtask

    initial begin
        cen_cnt = $urandom_range(0, 15);
        cen_3m = 1'b0;
        cs_rises = 0; irq_rises = 0; cs_high = 0; wdog_low = 0;
        test_reset();
        test_sound_write();
        test_irq();
        test_latch();
        test_reads();
        test_reset_mid_pulse();
        test_random();
        test_watchdog();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
